axicb_scfifo_fwft: RTL and testbench

//  Single-clock, first-word-fall-through FIFO for crossbar channel buffering.

---
 rtl/axicb_fifo_pkg.sv | 24 ++
 rtl/axicb_fifo_mem.sv | 52 +++++
 rtl/axicb_scfifo_fwft.sv | 159 +++++++++++++++
 tb/tb_axicb_scfifo_fwft.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axicb_fifo_pkg.sv
// Shared types and helpers for the axicb single-clock FIFO.
//   ptr_w(depth)   : pointer width for a power-of-two depth
//   fifo_status_t  : registered status flags {full, afull, empty, aempty}
//   out_state_e    : output/prefetch stage state
package axicb_fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_status_t;

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StLoading = 2'd1,
        StValid   = 2'd2
    } out_state_e;

endpackage

// File: rtl/axicb_fifo_mem.sv
// 1W/1R storage for the axicb FIFO.
//   clk              : clock
//   rst / clr        : async / sync clear of the read register only (RD_REG=1)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr    : read port (rd_en only matters when RD_REG=1)
//   rd_data          : async read (RD_REG=0) or registered read (RD_REG=1)
module axicb_fifo_mem #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          RD_REG     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] storage [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[wr_addr] <= wr_data;
        end
    end

    if (RD_REG) begin : g_rd_reg
        logic [DATA_WIDTH-1:0] rd_q;

        // Reset here gives a defined data_out after reset; the array itself is not reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else if (clr) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= storage[rd_addr];
            end
        end

        assign rd_data = rd_q;
    end else begin : g_rd_async
        logic unused_rd_ctrl;
        assign unused_rd_ctrl = ^{rst, clr, rd_en};
        assign rd_data        = storage[rd_addr];
    end

endmodule

// File: rtl/axicb_scfifo_fwft.sv
// Single-clock first-word-fall-through FIFO for crossbar channel buffering.
//   aclk, arst (async, high), srst (sync, high)
//   push/data_in/full/afull           : write side
//   pull/data_out/empty/aempty        : read side, data_out valid while empty=0
//   count                             : entries held, including the output stage
//   overflow/underflow                : one-cycle pulse after a rejected push/pull
// FFD_EN=1 uses a registered memory read; that register is the output stage.
module axicb_scfifo_fwft
    import axicb_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter bit          FFD_EN        = 1'b0,
    parameter int unsigned AFULL_THRESH  = 14,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                    aclk,
    input  logic                    arst,
    input  logic                    srst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    full,
    output logic                    afull,
    input  logic                    pull,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    empty,
    output logic                    aempty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    localparam fifo_status_t STATUS_RST = '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    out_state_e      state_q, state_d;
    fifo_status_t    status_q, status_d;
    logic            overflow_q, underflow_q;
    logic            push_ok, pull_ok, load, out_held, mem_empty;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign push_ok = push & ~status_q.full & ~srst;
    assign pull_ok = pull & ~status_q.empty & ~srst;

    // With FFD_EN=1 the head entry lives in the read register, not in memory.
    assign out_held  = FFD_EN && (state_q == StValid);
    assign mem_empty = (count_q == CW'(out_held));

    always_comb begin
        count_d = count_q;
        if (push_ok && !pull_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pull_ok) begin
            count_d = count_q - CW'(1);
        end

        state_d = state_q;
        load    = 1'b0;
        if (!FFD_EN) begin
            state_d = (count_d != '0) ? StValid : StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push_ok) state_d = StLoading;
                end
                StLoading: begin
                    load    = 1'b1;
                    state_d = StValid;
                end
                StValid: begin
                    if (pull_ok) begin
                        if (!mem_empty) begin
                            load = 1'b1;
                        end else if (push_ok) begin
                            // Entry being written now needs one read cycle.
                            state_d = StLoading;
                        end else begin
                            state_d = StEmpty;
                        end
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(FFD_EN ? load : pull_ok);

        if (srst) begin
            count_d  = '0;
            state_d  = StEmpty;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            load     = 1'b0;
        end

        status_d = '{
            full:   (count_d == DEPTH_C),
            afull:  (count_d >= AFULL_C),
            empty:  (state_d != StValid),
            aempty: (count_d <= AEMPTY_C)
        };
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StEmpty;
            status_q    <= STATUS_RST;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            status_q    <= status_d;
            overflow_q  <= push & status_q.full & ~srst;
            underflow_q <= pull & status_q.empty & ~srst;
        end
    end

    axicb_fifo_mem #(
        .ADDR_WIDTH (PW),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_REG     (FFD_EN)
    ) u_mem (
        .clk     (aclk),
        .rst     (arst),
        .clr     (srst),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (load),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    assign full      = status_q.full;
    assign afull     = status_q.afull;
    assign empty     = status_q.empty;
    assign aempty    = status_q.aempty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    // Async read shows stale storage when empty; force zero there.
    assign data_out  = (!FFD_EN && status_q.empty) ? '0 : mem_rd_data;

endmodule

// File: tb/tb_axicb_scfifo_fwft.sv
// Bench for axicb_scfifo_fwft: one instance per FFD_EN setting, shared stimulus.
// Reference model: a list of accepted entries with the clock edge each was
// pushed on; the head is visible once it has aged by the read latency.
module tb_axicb_scfifo_fwft;

    localparam int DEPTH = 4;
    localparam int MSZ   = 1024;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    logic srst = 1'b0;
    logic push = 1'b0;
    logic pull = 1'b0;
    logic [7:0] din = '0;

    logic [1:0]      full, afull, empty, aempty, ovf, unf;
    logic [1:0][7:0] dout;
    logic [1:0][2:0] cnt;

    always #5 clk = ~clk;

    axicb_scfifo_fwft #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .FFD_EN(1'b0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) dut0 (
        .aclk(clk), .arst(arst), .srst(srst), .push(push), .data_in(din),
        .full(full[0]), .afull(afull[0]), .pull(pull), .data_out(dout[0]),
        .empty(empty[0]), .aempty(aempty[0]), .count(cnt[0]),
        .overflow(ovf[0]), .underflow(unf[0])
    );

    axicb_scfifo_fwft #(
        .DATA_WIDTH(8), .DEPTH(DEPTH), .FFD_EN(1'b1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
    ) dut1 (
        .aclk(clk), .arst(arst), .srst(srst), .push(push), .data_in(din),
        .full(full[1]), .afull(afull[1]), .pull(pull), .data_out(dout[1]),
        .empty(empty[1]), .aempty(aempty[1]), .count(cnt[1]),
        .overflow(ovf[1]), .underflow(unf[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: entries [mh, mtl) per instance, data and push-edge index.
    logic [7:0] md [2][MSZ];
    int         mt [2][MSZ];
    int         mh [2];
    int         mtl[2];
    int         edge_n = 0;
    bit         e_ovf[2];
    bit         e_unf[2];
    logic [7:0] sb0[$];
    logic [7:0] sb1[$];
    bit         mon_en = 1'b0;

    function automatic void chk(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s ffd=%0d t=%0t got %0h want %0h", name, c, $time, act, exp);
    endfunction

    function automatic int msize(int c);
        return mtl[c] - mh[c];
    endfunction

    // Read latency is 1 edge for FFD_EN=0 and 2 edges for FFD_EN=1.
    function automatic bit mvis(int c);
        return (msize(c) > 0) && (mt[c][mh[c] % MSZ] <= edge_n - c);
    endfunction

    function automatic void sb_push(int c, logic [7:0] d);
        if (c == 0) sb0.push_back(d);
        else        sb1.push_back(d);
    endfunction

    // Monitor: status against the model every cycle, pulled data against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int c = 0; c < 2; c++) begin
                    chk("count", c, cnt[c], msize(c));
                    chk("full", c, full[c], msize(c) == DEPTH);
                    chk("afull", c, afull[c], msize(c) >= 3);
                    chk("aempty", c, aempty[c], msize(c) <= 1);
                    chk("empty", c, empty[c], !mvis(c));
                    chk("overflow", c, ovf[c], e_ovf[c]);
                    chk("underflow", c, unf[c], e_unf[c]);
                    if (mvis(c)) chk("head", c, dout[c], md[c][mh[c] % MSZ]);
                    if (pull && !srst && !empty[c]) begin
                        if ((c == 0 && sb0.size() == 0) || (c == 1 && sb1.size() == 0)) begin
                            n_checks++;
                            $display("FAIL pop_unexpected ffd=%0d t=%0t got %0h want none",
                                     c, $time, dout[c]);
                        end else if (c == 0) begin
                            chk("pop_data", c, dout[c], sb0.pop_front());
                        end else begin
                            chk("pop_data", c, dout[c], sb1.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1; drives inputs for the next edge and advances the model.
    task automatic cyc(input bit p, input logic [7:0] d, input bit pl, input bit sr);
        bit pok[2];
        bit plok[2];
        bit ovn[2];
        bit unn[2];
        for (int c = 0; c < 2; c++) begin
            bit fm;
            bit em;
            fm      = (msize(c) == DEPTH);
            em      = !mvis(c);
            pok[c]  = p && !fm && !sr;
            plok[c] = pl && !em && !sr;
            ovn[c]  = p && fm && !sr;
            unn[c]  = pl && em && !sr;
            if (plok[c]) sb_push(c, md[c][mh[c] % MSZ]);
        end
        push = p;
        din  = d;
        pull = pl;
        srst = sr;
        @(posedge clk);
        #1;
        edge_n++;
        for (int c = 0; c < 2; c++) begin
            if (sr) begin
                mh[c] = mtl[c];
            end else begin
                if (pok[c]) begin
                    md[c][mtl[c] % MSZ] = d;
                    mt[c][mtl[c] % MSZ] = edge_n;
                    mtl[c]++;
                end
                if (plok[c]) mh[c]++;
            end
            e_ovf[c] = ovn[c];
            e_unf[c] = unn[c];
        end
    endtask

    task automatic do_arst();
        arst = 1'b1;
        #2;
        for (int c = 0; c < 2; c++) begin
            chk("arst_empty", c, empty[c], 1);
            chk("arst_full", c, full[c], 0);
            chk("arst_count", c, cnt[c], 0);
            chk("arst_aempty", c, aempty[c], 1);
            chk("arst_afull", c, afull[c], 0);
            chk("arst_dout", c, dout[c], 0);
            chk("arst_ovf", c, ovf[c], 0);
        end
        arst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            mh[c]    = mtl[c];
            e_ovf[c] = 1'b0;
            e_unf[c] = 1'b0;
        end
        sb0.delete();
        sb1.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        int pp;
        mh[0] = 0; mh[1] = 0; mtl[0] = 0; mtl[1] = 0;
        @(posedge clk);
        #1;
        do_arst();

        // Fill past full, then drain past empty.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Single-entry latency.
        cyc(1'b1, 8'h5C, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Concurrent push+pull at count 2 across pointer wrap, then at full.
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h12 + 8'(i), 1'b1, 1'b0);
        cyc(1'b1, 8'h30, 1'b0, 1'b0);
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // srst with push at count 3.
        cyc(1'b1, 8'h40, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with shifting push/pull balance and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            case ((i / 250) % 3)
                0:       pp = 70;
                1:       pp = 50;
                default: pp = 30;
            endcase
            if ($urandom_range(299) == 0) do_arst();
            cyc($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) < (100 - pp),
                $urandom_range(63) == 0);
        end

        // Drain whatever is left and confirm the scoreboard emptied.
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("sb_left", 0, sb0.size(), 0);
        chk("sb_left", 1, sb1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
